// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the unified instruction/data memory.
// One transaction in flight; requester fields are latched at grant.
module mem_port_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int unsigned CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          p0_ack_q, p0_ack_d;
  logic          p1_ack_q, p1_ack_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic          busy_q, busy_d;
  logic          gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Outputs are computed from the next state so they are valid in the state they belong to.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    gnt         = 1'b0;

    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          // On a tie the port that did not win last time gets the grant.
          gnt         = (p0_req && p1_req) ? ~last_q : p1_req;
          owner_d     = gnt;
          last_d      = gnt;
          we_d        = gnt ? p1_we    : p0_we;
          mem_addr_d  = gnt ? p1_addr  : p0_addr;
          mem_wdata_d = gnt ? p1_wdata : p0_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d  = DONE;
          p0_ack_d = ~owner_q;
          p1_ack_d = owner_q;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (cnt_q == CW'(RD_LAT)) begin
          if (owner_q) p1_rdata_d = mem_rdata;
          else         p0_rdata_d = mem_rdata;
          state_d  = DONE;
          p0_ack_d = ~owner_q;
          p1_ack_d = owner_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps on an RD_LAT=1 instance, then random
// traffic on an RD_LAT=3 instance, all checked against a transaction-level model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [1:0] ack0, ack1, en, mwe, busy, owner;
  logic [1:0][31:0] rd0, rd1, maddr, mwdata, mrd;
  logic sel;
  logic rst_l3;

  always #5 clk = ~clk;

  assign rst_l3 = reset | ~sel;

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(ack0[0]), .p0_rdata(rd0[0]),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(ack1[0]), .p1_rdata(rd1[0]),
    .mem_en(en[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_wdata(mwdata[0]),
    .mem_rdata(mrd[0]), .busy(busy[0]), .owner(owner[0])
  );

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .reset(rst_l3),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(ack0[1]), .p0_rdata(rd0[1]),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(ack1[1]), .p1_rdata(rd1[1]),
    .mem_en(en[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_wdata(mwdata[1]),
    .mem_rdata(mrd[1]), .busy(busy[1]), .owner(owner[1])
  );

  // Memory macros: read data is only valid RD_LAT cycles after mem_en, junk otherwise.
  bit [31:0] mem_l1 [256];
  bit [31:0] mem_l3 [256];
  bit        pv1;
  bit [31:0] pd1, junk1, junk3;
  bit [2:0]  pv3;
  bit [31:0] pd3 [3];
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) begin
      mem_l1[ld_addr] <= ld_data;
      mem_l3[ld_addr] <= ld_data;
    end
    if (en[0] && mwe[0]) mem_l1[maddr[0][7:0]] <= mwdata[0];
    if (en[1] && mwe[1]) mem_l3[maddr[1][7:0]] <= mwdata[1];
    pv1    <= en[0] && !mwe[0];
    pd1    <= mem_l1[maddr[0][7:0]];
    pv3    <= {pv3[1:0], en[1] && !mwe[1]};
    pd3[0] <= mem_l3[maddr[1][7:0]];
    pd3[1] <= pd3[0];
    pd3[2] <= pd3[1];
    junk1  <= $urandom;
    junk3  <= $urandom;
  end

  assign mrd[0] = pv1    ? pd1    : junk1;
  assign mrd[1] = pv3[2] ? pd3[2] : junk3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level reference model.
  int        checks = 0;
  int        errors = 0;
  int        lat;
  bit [31:0] ref_mem [256];
  bit        m_infl, m_port, m_we, m_last, m_owner;
  int        m_gc, m_ackc, m_free;
  bit [31:0] m_addr, m_wdata, m_rdv, m_maddr, m_mwdata;
  bit [31:0] m_rdata [2];
  bit        ack_seen [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset(input int c);
    m_infl     = 1'b0;
    m_last     = 1'b1;
    m_owner    = 1'b0;
    m_maddr    = '0;
    m_mwdata   = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    m_free     = c + 1;
  endtask

  // Decide what the arbiter does with the inputs sampled at the end of cycle c.
  task automatic commit(input int c);
    if (reset) begin
      model_reset(c);
    end else if (c >= m_free && (p0_req || p1_req)) begin
      m_port  = (p0_req && p1_req) ? !m_last : p1_req;
      m_last  = m_port;
      m_infl  = 1'b1;
      m_gc    = c;
      m_we    = m_port ? p1_we    : p0_we;
      m_addr  = m_port ? p1_addr  : p0_addr;
      m_wdata = m_port ? p1_wdata : p0_wdata;
      m_ackc  = c + 2 + (m_we ? 0 : lat);
      m_free  = m_ackc + 1;
      if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
      else      m_rdv = ref_mem[m_addr[7:0]];
    end
  endtask

  task automatic check(input int c);
    bit e_ack0, e_ack1, e_en, e_busy;
    if (m_infl && c == m_gc + 1) begin
      m_owner  = m_port;
      m_maddr  = m_addr;
      m_mwdata = m_wdata;
    end
    if (m_infl && c == m_ackc && !m_we) m_rdata[m_port] = m_rdv;
    e_ack0 = m_infl && c == m_ackc && !m_port;
    e_ack1 = m_infl && c == m_ackc && m_port;
    e_en   = m_infl && c == m_gc + 1;
    e_busy = m_infl && c > m_gc && c <= m_ackc;
    chk("p0_ack",    32'(ack0[sel]), 32'(e_ack0));
    chk("p1_ack",    32'(ack1[sel]), 32'(e_ack1));
    chk("mem_en",    32'(en[sel]),   32'(e_en));
    chk("mem_we",    32'(mwe[sel]),  32'(e_en && m_we));
    chk("mem_addr",  maddr[sel],     m_maddr);
    chk("mem_wdata", mwdata[sel],    m_mwdata);
    chk("busy",      32'(busy[sel]), 32'(e_busy));
    chk("owner",     32'(owner[sel]), 32'(m_owner));
    chk("p0_rdata",  rd0[sel],       m_rdata[0]);
    chk("p1_rdata",  rd1[sel],       m_rdata[1]);
    ack_seen[0] = ack0[sel];
    ack_seen[1] = ack1[sel];
    if (m_infl && c == m_ackc) m_infl = 1'b0;
  endtask

  task automatic step();
    commit(cyc);
    @(negedge clk);
    check(cyc);
  endtask

  task automatic drive(input int p, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d);
    if (p == 0) begin
      p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic wait_ack(input int p, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ack_seen[p]) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    ref_mem[a] = d;
    step();
    ld_en = 1'b0;
  endtask

  initial begin
    int t;
    int order [$];
    int exp_order [4] = '{0, 1, 0, 1};
    bit pend [2];
    bit got;

    sel = 1'b0; lat = 1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    model_reset(0);
    @(negedge clk);
    do_reset();
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_owner", 32'(owner[0]), 32'd0);

    // Single write on port 0.
    drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    t = cyc;
    wait_ack(0, "t1_ack_timeout");
    chk("t1_latency", 32'(cyc - t), 32'd2);
    p0_req = 1'b0;
    step();

    // Single read on port 1 with a one-cycle memory.
    preload(8'h20, 32'h12345678);
    drive(1, 1'b1, 1'b0, 32'h20, 32'h0);
    t = cyc;
    wait_ack(1, "t2_ack_timeout");
    chk("t2_latency", 32'(cyc - t), 32'd3);
    chk("t2_rdata", rd1[0], 32'h12345678);
    p1_req = 1'b0;
    step();

    // Both ports held high from reset: grants must alternate starting with port 0.
    do_reset();
    drive(0, 1'b1, 1'b1, 32'h01, 32'hA0A0A0A0);
    drive(1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        step();
        if (ack_seen[0] && ack_seen[1]) chk("t3_dual_ack", 32'd1, 32'd0);
        if (ack_seen[0] || ack_seen[1]) begin
          got = 1'b1;
          order.push_back(ack_seen[1] ? 1 : 0);
          if (ack_seen[0]) p0_addr = p0_addr + 32'd1;
        end
      end
    end
    chk("t3_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk("t3_order", 32'(order[i]), 32'(exp_order[i]));
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    step();

    // Requester fields change while the read is in WAIT.
    preload(8'h30, 32'hCAFEF00D);
    drive(0, 1'b1, 1'b0, 32'h30, 32'h0);
    step();
    step();
    drive(0, 1'b1, 1'b1, 32'hFF, 32'h55555555);
    wait_ack(0, "t4_ack_timeout");
    chk("t4_rdata", rd0[0], 32'hCAFEF00D);
    chk("t4_addr", maddr[0], 32'h30);
    p0_req = 1'b0;
    step();

    // Reset during WAIT aborts the read.
    drive(0, 1'b1, 1'b0, 32'h30, 32'h0);
    step();
    step();
    reset = 1'b1;
    p0_req = 1'b0;
    step();
    chk("t5_busy", 32'(busy[0]), 32'd0);
    chk("t5_ack", 32'(ack0[0]), 32'd0);
    chk("t5_rdata", rd0[0], 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Random back-to-back traffic against the three-cycle memory.
    sel = 1'b1; lat = 3;
    do_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int k = 0; k < 600; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (ack_seen[p]) pend[p] = 1'b0;
        if (!pend[p]) begin
          if ($urandom % 4 != 0) begin
            drive(p, 1'b1, 1'($urandom % 2), 32'h80 + 32'($urandom % 16), $urandom);
            pend[p] = 1'b1;
          end else begin
            drive(p, 1'b0, 1'b0, '0, '0);
          end
        end else if (m_infl && m_port == 1'(p) && cyc > m_gc) begin
          drive(p, (p == 0 ? p0_req : p1_req) && ($urandom % 8 != 0),
                1'($urandom % 2), $urandom, $urandom);
        end
      end
      step();
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 12; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
